// File: rtl/des_pkg.sv
// Shared DES constants for the round core: FIPS 46-3 permutation tables (bit 1 = MSB),
// S-boxes, FSM state type and the permutation helpers built from those tables.
package des_pkg;

    localparam int NUM_ROUNDS = 16;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

    localparam int IP [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int IP_INV [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // Each S-box is stored row-major: entry index = {b1, b6, b2..b5} of the 6-bit input.
    typedef logic [3:0] sbox_t [8][64];

    localparam sbox_t SBOX = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
           0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
           4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
           3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
           0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
           1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{ 7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
           3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{ 2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
           4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
           9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
           4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{ 4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
           1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
           6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
           1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
           7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
           2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}
    };

    // Output bit j (counted from the MSB) takes input bit TABLE[j] (also counted from the MSB).
    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP[j])];
        return y;
    endfunction

    function automatic logic [63:0] ip_inv_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP_INV[j])];
        return y;
    endfunction

    function automatic logic [47:0] e_perm(input logic [31:0] x);
        logic [47:0] y;
        for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[5'(32 - E[j])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        for (int j = 0; j < 32; j++) y[5'(31 - j)] = x[5'(32 - P[j])];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        for (int j = 0; j < 56; j++) y[6'(55 - j)] = x[6'(64 - PC1[j])];
        return y;
    endfunction

endpackage

// File: rtl/des_round_core_if.sv
// Bundle of the round core's block, subkey-schedule and result signals, with the
// environment (master) and core (slave) views.
interface des_round_core_if;
    logic [63:0] data_in;
    logic [63:0] key_in;
    logic        decrypt_in;
    logic        in_valid_in;
    logic        in_ready_out;
    logic [63:0] sched_key_out;
    logic [3:0]  sched_idx_out;
    logic        sched_valid_out;
    logic [47:0] subkey_in;
    logic        subkey_valid_in;
    logic [63:0] data_out;
    logic        out_valid_out;
    logic        out_ready_in;

    modport master (
        output data_in, key_in, decrypt_in, in_valid_in, subkey_in, subkey_valid_in, out_ready_in,
        input  in_ready_out, sched_key_out, sched_idx_out, sched_valid_out, data_out, out_valid_out
    );

    modport slave (
        input  data_in, key_in, decrypt_in, in_valid_in, subkey_in, subkey_valid_in, out_ready_in,
        output in_ready_out, sched_key_out, sched_idx_out, sched_valid_out, data_out, out_valid_out
    );
endinterface

// File: rtl/des_f.sv
// DES round function f(R, K): E-expansion, key mix, S1..S8 substitution, P-permutation.
module des_f
    import des_pkg::*;
(
    input  logic [31:0] r_i,
    input  logic [47:0] k_i,
    output logic [31:0] f_o
);

    logic [47:0] mixed_w;
    logic [31:0] sub_w;

    assign mixed_w = e_perm(r_i) ^ k_i;

    for (genvar i = 0; i < 8; i++) begin : g_sbox
        logic [5:0] six_w;
        assign six_w = mixed_w[47 - 6*i -: 6];
        // Outer bits select the row, inner four the column.
        assign sub_w[31 - 4*i -: 4] = SBOX[i][{six_w[5], six_w[0], six_w[4:1]}];
    end

    assign f_o = p_perm(sub_w);

endmodule

// File: rtl/des_round_core.sv
// Iterative DES engine: one Feistel round per returned subkey, subkeys requested one
// index per cycle from the external des_key schedule.
module des_round_core
    import des_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [63:0] data_in,
    input  logic [63:0] key_in,
    input  logic        decrypt_in,
    input  logic        in_valid_in,
    output logic        in_ready_out,
    output logic [63:0] sched_key_out,
    output logic [3:0]  sched_idx_out,
    output logic        sched_valid_out,
    input  logic [47:0] subkey_in,
    input  logic        subkey_valid_in,
    output logic [63:0] data_out,
    output logic        out_valid_out,
    input  logic        out_ready_in
);

    localparam logic [4:0] ISS_END  = 5'(NUM_ROUNDS);
    localparam logic [3:0] RND_LAST = 4'(NUM_ROUNDS - 1);

    state_e      state_q, state_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [63:0] key_q, key_d;
    logic [63:0] data_q, data_d;
    logic        dec_q, dec_d;
    logic [4:0]  iss_q, iss_d;
    logic [3:0]  rnd_q, rnd_d;

    logic [31:0] f_w;
    logic [55:0] pc1_w;
    logic [31:0] l_new_w, r_new_w;

    des_f u_f (
        .r_i (r_q),
        .k_i (subkey_in),
        .f_o (f_w)
    );

    assign pc1_w   = pc1_perm(key_in);
    assign l_new_w = r_q;
    assign r_new_w = l_q ^ f_w;

    // NOTE: every always_comb target takes its held value first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        key_d   = key_q;
        data_d  = data_q;
        dec_d   = dec_q;
        iss_d   = iss_q;
        rnd_d   = rnd_q;
        case (state_q)
            IDLE: if (in_valid_in) begin
                state_d    = LOAD;
                {l_d, r_d} = ip_perm(data_in);
                // des_key expects C (first PC-1 half) in the low 28 bits.
                key_d      = {8'h00, pc1_w[27:0], pc1_w[55:28]};
                dec_d      = decrypt_in;
                iss_d      = '0;
                rnd_d      = '0;
            end
            LOAD: state_d = RUN;
            RUN: begin
                if (iss_q < ISS_END) iss_d = iss_q + 5'd1;
                if (subkey_valid_in) begin
                    l_d   = l_new_w;
                    r_d   = r_new_w;
                    rnd_d = rnd_q + 4'd1;
                    if (rnd_q == RND_LAST) begin
                        state_d = DONE;
                        data_d  = ip_inv_perm({r_new_w, l_new_w});
                    end
                end
            end
            DONE: if (out_ready_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            l_q     <= '0;
            r_q     <= '0;
            key_q   <= '0;
            data_q  <= '0;
            dec_q   <= 1'b0;
            iss_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            key_q   <= key_d;
            data_q  <= data_d;
            dec_q   <= dec_d;
            iss_q   <= iss_d;
            rnd_q   <= rnd_d;
        end
    end

    assign in_ready_out    = (state_q == IDLE);
    assign out_valid_out   = (state_q == DONE);
    assign sched_valid_out = (state_q == RUN) && (iss_q < ISS_END);
    assign sched_idx_out   = !sched_valid_out ? 4'd0
                           : dec_q            ? RND_LAST - iss_q[3:0]
                           :                    iss_q[3:0];
    assign sched_key_out   = key_q;
    assign data_out        = data_q;

endmodule

// File: tb/tb_des_round_core.sv
// Directed bench for des_round_core with a behavioural des_key schedule (1-cycle latency)
// and known-answer DES vectors.
module tb_des_round_core;

    logic clk_in = 1'b0;
    logic rst_in;
    always #5 clk_in = ~clk_in;

    des_round_core_if bus ();

    des_round_core dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .data_in         (bus.data_in),
        .key_in          (bus.key_in),
        .decrypt_in      (bus.decrypt_in),
        .in_valid_in     (bus.in_valid_in),
        .in_ready_out    (bus.in_ready_out),
        .sched_key_out   (bus.sched_key_out),
        .sched_idx_out   (bus.sched_idx_out),
        .sched_valid_out (bus.sched_valid_out),
        .subkey_in       (bus.subkey_in),
        .subkey_valid_in (bus.subkey_valid_in),
        .data_out        (bus.data_out),
        .out_valid_out   (bus.out_valid_out),
        .out_ready_in    (bus.out_ready_in)
    );

    localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] FIPS_PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] FIPS_CT  = 64'h85E813540F0AB405;
    localparam logic [63:0] V2_KEY   = 64'h0E329232EA6D0D73;
    localparam logic [63:0] V2_PT    = 64'h8787878787878787;
    localparam logic [63:0] V2_CT    = 64'h0000000000000000;

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int proto_err = 0;
    logic [3:0] idx_log [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Subkey for round idx from the {D, C} layout the core drives to des_key.
    function automatic logic [47:0] subkey_of(input logic [63:0] sk, input logic [3:0] idx);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] k;
        c = sk[27:0];
        d = sk[55:28];
        for (int r = 0; r <= int'(idx); r++)
            for (int s = 0; s < SHIFTS[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
        cd = {c, d};
        for (int j = 0; j < 48; j++) k[6'(47 - j)] = cd[6'(56 - PC2[j])];
        return k;
    endfunction

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (rst_in) begin
            bus.subkey_valid_in <= 1'b0;
            bus.subkey_in       <= '0;
        end else begin
            bus.subkey_valid_in <= bus.sched_valid_out;
            bus.subkey_in       <= subkey_of(bus.sched_key_out, bus.sched_idx_out);
        end
    end

    always @(negedge clk_in) begin
        if (bus.subkey_valid_in && (bus.in_ready_out || bus.out_valid_out)) proto_err++;
        if (bus.sched_valid_out) idx_log.push_back(bus.sched_idx_out);
    end

    task automatic wait_valid(input string tag, input int t0);
        int n = 0;
        while (!bus.out_valid_out && n < 60) begin
            @(negedge clk_in);
            n++;
        end
        check({tag, "_latency"}, 64'(cyc - t0), 64'd19);
    endtask

    task automatic run_op(input string tag, input logic [63:0] key, input logic [63:0] data,
                          input logic dec, input logic [63:0] exp);
        int t0;
        int bad = 0;
        idx_log.delete();
        check({tag, "_in_ready"}, 64'(bus.in_ready_out), 64'd1);
        bus.key_in      = key;
        bus.data_in     = data;
        bus.decrypt_in  = dec;
        bus.in_valid_in = 1'b1;
        t0 = cyc;
        @(negedge clk_in);
        bus.in_valid_in = 1'b0;
        wait_valid(tag, t0);
        check({tag, "_data"}, bus.data_out, exp);
        check({tag, "_pulses"}, 64'(idx_log.size()), 64'd16);
        foreach (idx_log[i])
            if (int'(idx_log[i]) != (dec ? 15 - i : i)) bad++;
        check({tag, "_idx_order"}, 64'(bad), 64'd0);
        @(negedge clk_in);
        check({tag, "_out_done"}, 64'(bus.out_valid_out), 64'd0);
        check({tag, "_ready_back"}, 64'(bus.in_ready_out), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready_out), 64'd1);
        check({tag, "_sched_valid"}, 64'(bus.sched_valid_out), 64'd0);
        check({tag, "_sched_idx"}, 64'(bus.sched_idx_out), 64'd0);
        check({tag, "_sched_key"}, bus.sched_key_out, 64'd0);
        check({tag, "_out_valid"}, 64'(bus.out_valid_out), 64'd0);
        check({tag, "_data"}, bus.data_out, 64'd0);
    endtask

    initial begin
        logic [63:0] keys [3];
        logic [63:0] pts  [3];
        logic        decs [3];
        logic [63:0] exps [3];
        int          t_acc [3];
        int          t0;
        int          stray;

        rst_in           = 1'b1;
        bus.data_in      = '0;
        bus.key_in       = '0;
        bus.decrypt_in   = 1'b0;
        bus.in_valid_in  = 1'b0;
        bus.out_ready_in = 1'b1;
        repeat (2) @(negedge clk_in);
        check_reset_outputs("reset");
        rst_in = 1'b0;
        @(negedge clk_in);

        run_op("fips_enc", FIPS_KEY, FIPS_PT, 1'b0, FIPS_CT);
        run_op("fips_dec", FIPS_KEY, FIPS_CT, 1'b1, FIPS_PT);
        run_op("v2_enc", V2_KEY, V2_PT, 1'b0, V2_CT);

        // Back-pressure, with junk presented while the core is busy.
        bus.out_ready_in = 1'b0;
        bus.key_in       = FIPS_KEY;
        bus.data_in      = FIPS_PT;
        bus.decrypt_in   = 1'b0;
        bus.in_valid_in  = 1'b1;
        t0 = cyc;
        @(negedge clk_in);
        bus.data_in    = 64'hDEADBEEFCAFEF00D;
        bus.key_in     = V2_KEY;
        bus.decrypt_in = 1'b1;
        wait_valid("bp", t0);
        check("bp_data", bus.data_out, FIPS_CT);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            check("bp_hold_valid", 64'(bus.out_valid_out), 64'd1);
            check("bp_hold_data", bus.data_out, FIPS_CT);
            check("bp_hold_not_ready", 64'(bus.in_ready_out), 64'd0);
        end
        bus.out_ready_in = 1'b1;
        @(negedge clk_in);
        check("bp_release_valid", 64'(bus.out_valid_out), 64'd0);
        check("bp_release_ready", 64'(bus.in_ready_out), 64'd1);
        bus.in_valid_in = 1'b0;
        @(negedge clk_in);
        check("bp_no_stray_accept", 64'(bus.in_ready_out), 64'd1);

        // Reset during RUN: the partial block must never surface.
        bus.key_in      = FIPS_KEY;
        bus.data_in     = FIPS_PT;
        bus.decrypt_in  = 1'b0;
        bus.in_valid_in = 1'b1;
        @(negedge clk_in);
        bus.in_valid_in = 1'b0;
        repeat (9) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        check_reset_outputs("mid_rst");
        rst_in = 1'b0;
        stray = 0;
        repeat (25) begin
            @(negedge clk_in);
            if (bus.out_valid_out) stray++;
        end
        check("mid_rst_no_output", 64'(stray), 64'd0);
        run_op("post_rst_enc", FIPS_KEY, FIPS_PT, 1'b0, FIPS_CT);

        // Back-to-back with in_valid held high.
        keys = '{FIPS_KEY, FIPS_KEY, V2_KEY};
        pts  = '{FIPS_PT, FIPS_CT, V2_PT};
        decs = '{1'b0, 1'b1, 1'b0};
        exps = '{FIPS_CT, FIPS_PT, V2_CT};
        bus.key_in      = keys[0];
        bus.data_in     = pts[0];
        bus.decrypt_in  = decs[0];
        bus.in_valid_in = 1'b1;
        for (int v = 0; v < 3; v++) begin
            check("b2b_in_ready", 64'(bus.in_ready_out), 64'd1);
            t_acc[v] = cyc;
            if (v > 0) check("b2b_spacing", 64'(t_acc[v] - t_acc[v-1]), 64'd20);
            @(negedge clk_in);
            if (v < 2) begin
                bus.key_in     = keys[v+1];
                bus.data_in    = pts[v+1];
                bus.decrypt_in = decs[v+1];
            end
            wait_valid("b2b", t_acc[v]);
            check("b2b_data", bus.data_out, exps[v]);
            if (v == 2) bus.in_valid_in = 1'b0;
            @(negedge clk_in);
        end
        check("b2b_final_ready", 64'(bus.in_ready_out), 64'd1);

        check("protocol_subkey_outside_run", 64'(proto_err), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/des_round_core.md
# des_round_core

Iterative single-block DES encrypt/decrypt engine that sits directly downstream of the `des_key` subkey schedule. It accepts a 64-bit block and a 64-bit key over a valid/ready handshake, applies PC-1 and drives the result to `des_key`, then requests one subkey index per cycle. It consumes each registered 48-bit subkey as it returns, runs one Feistel round per cycle, and presents the IP⁻¹ result on a valid/ready output.

## Interface
Parameters: none (all tables are constants in `des_pkg`).

Ports:
- `clk_in` input 1 — single clock, rising edge.
- `rst_in` input 1 — reset, synchronous, active-high.
- `data_in` input 64 — plaintext or ciphertext block.
- `key_in` input 64 — DES key, parity bits ignored.
- `decrypt_in` input 1 — 0 = encrypt, 1 = decrypt; sampled with the block.
- `in_valid_in` input 1 — block, key and mode are valid.
- `in_ready_out` output 1 — core can accept a new block.
- `sched_key_out` output 64 — to `des_key.key_in`; `{8'b0, PC1(key)}`, with C in [27:0] and D in [55:28].
- `sched_idx_out` output 4 — to `des_key.key_idx_in`.
- `sched_valid_out` output 1 — to `des_key.key_in_valid`.
- `subkey_in` input 48 — from `des_key.key_out`.
- `subkey_valid_in` input 1 — from `des_key.key_out_valid`.
- `data_out` output 64 — result block.
- `out_valid_out` output 1 — result valid.
- `out_ready_in` input 1 — consumer accepts the result.

## Operation
- States are IDLE, LOAD, RUN, DONE.
- `in_ready_out` = (state == IDLE), combinational.
- **IDLE → LOAD** when `in_valid_in` is high:
  - register {L,R} = IP(`data_in`);
  - register `sched_key_out` = PC-1(`key_in`);
  - register the mode;
  - clear the issue counter `iss` and the round counter `rnd`.
- **LOAD → RUN** after one cycle. `sched_key_out` is then stable for the whole operation.
- **RUN, issue side:**
  - While `iss` < 16: `sched_valid_out` = 1 and `sched_idx_out` = `iss` for encrypt, or 15 − `iss` for decrypt; then `iss`++.
  - `sched_valid_out` is 0 otherwise.
- **RUN, consume side:**
  - On `subkey_valid_in`: L ← R, R ← L ^ f(R, `subkey_in`); `rnd`++.
  - If `rnd` was 15, go to DONE and register `data_out` = IP⁻¹({R', L'}), i.e. the final swap is undone before IP⁻¹.
- **f(R, K):** E-expansion to 48 bits, XOR with K, S1..S8 (6→4 each), then P-permutation to 32 bits. All tables are FIPS 46-3, MSB = bit 1.
- **DONE:** `out_valid_out` = 1 and `data_out` is held until `out_ready_in` is high, then → IDLE. A new input cannot be accepted in the same cycle as the output handshake.
- **Protocol rule:** `subkey_valid_in` is never high in IDLE, LOAD or DONE. The bench flags any occurrence as an error; the RTL ignores it.
- **Reset:** the synchronous reset overrides any state, including mid-RUN or DONE. The next state is IDLE. A partial result is discarded and is never output.

## Timing
- Cycle 0: input handshake (`in_valid_in` high in IDLE).
- Cycle 1: LOAD.
- Cycles 2..17: `sched_valid_out` high, one index per cycle: 0..15 for encrypt, 15..0 for decrypt.
- Cycles 3..18: `subkey_valid_in` returns, with one cycle of `des_key` latency. One round is applied per cycle.
- Cycle 19: `out_valid_out` high. Latency is 19 cycles from input handshake to output valid.
- Throughput is one block per 20 cycles when `out_ready_in` is tied high.
- Reset values (registers after the reset edge):
  - `in_ready_out` 1;
  - `sched_valid_out` 0, `sched_idx_out` 0, `sched_key_out` 0;
  - `out_valid_out` 0, `data_out` 0;
  - L/R 0, `iss` 0, `rnd` 0.
- Back-pressure: `data_out` is stable while `out_valid_out` is high and `out_ready_in` is low.

## Structure
- **`des_pkg`** holds:
  - permutation constants: IP, IP_INV, E, P, PC1;
  - the S-box table `sbox_t [8][64]` of 4-bit entries;
  - `typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE}`;
  - the constant `NUM_ROUNDS = 16`.
- **`des_f`** is one combinational sub-module: inputs R[31:0] and K[47:0], output f[31:0].
- All permutations use the package tables. There are no hand-written bit lists.

## Test plan
- **Encrypt, FIPS example:** key 133457799BBCDFF1, data 0123456789ABCDEF, mode encrypt, `out_ready_in` = 1 → `data_out` 85E813540F0AB405 with `out_valid_out` at cycle 19. Exactly 16 `sched_valid_out` pulses, index order 0..15.
- **Decrypt:** same key, data 85E813540F0AB405, mode decrypt → `data_out` 0123456789ABCDEF. Index order 15..0.
- **Second vector:** key 0E329232EA6D0D73, data 8787878787878787, mode encrypt → `data_out` 0000000000000000.
- **Back-pressure and handshake:**
  - Hold `out_ready_in` = 0 for 10 cycles after valid → `data_out` and `out_valid_out` are stable, and `in_ready_out` stays 0.
  - Release → one-cycle handshake, then `in_ready_out` = 1.
  - Inputs presented while `in_ready_out` = 0 are ignored.
- **Reset mid-RUN:** assert `rst_in` at cycle 10 → the next cycle is IDLE with all outputs at reset values and no `out_valid_out`. A fresh FIPS encrypt afterwards gives 85E813540F0AB405.
- **Back-to-back:** three blocks with `in_valid_in` held high → each accepted in the IDLE cycle after the previous output handshake (20-cycle spacing). All three results are correct.
